sensor_distancia_hcsr04: RTL and testbench
==========================================

Name: sensor_distancia_hcsr04

Overview:
- Upstream stage of the LCD message block: drives an HC-SR04-style ultrasonic ranger, measures echo width and converts it to centimetres without a divider.
- Produces the 1-bit `distancia` presence flag that the LCD message block consumes, plus the raw distance and status for debug or display.
- Free-running: one measurement per PERIOD_US.

Parameters:
- CLK_MHZ, 50, system clock frequency in MHz; all timing derives from it.
- TRIG_US, 10, trigger pulse width in µs.
- PERIOD_US, 60000, trigger-to-trigger period in µs; must exceed 2*TIMEOUT_US.
- TIMEOUT_US, 25000, maximum wait for echo rise, and maximum echo width, in µs.
- UMBRAL_CM, 20, presence threshold in cm.
- DW, 9, width of dist_cm.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- echo  input  1  sensor echo line, asynchronous to clk.
- trig  output  1  sensor trigger pulse.
- dist_cm  output  DW  last measured distance in cm.
- distancia  output  1  1 = object closer than UMBRAL_CM; feeds the LCD message block.
- valid  output  1  one-cycle pulse when dist_cm, distancia and err update.
- err  output  1  1 = last measurement timed out.

Behaviour:
- Reset (reset=0, async):
  - trig=0, dist_cm=0, distancia=0, valid=0, err=0.
  - All counters 0; state IDLE.
  - Asserting reset mid-measurement drops trig and clears outputs immediately; no partial result is ever published.
- Echo input: 2-FF synchroniser to echo_s, plus a third flop for rise/fall detection. Edge latency is 3 clocks on both edges, so the measured width equals the true width ±1 clock.
- Period counter: counts clocks, is cleared on entry to TRIG, and saturates at PERIOD_US*CLK_MHZ.
- States:
  - IDLE: trig=0. Go to TRIG when the period counter has saturated. After reset, the first TRIG occurs PERIOD_US after reset release.
  - TRIG: trig=1 for exactly TRIG_US*CLK_MHZ clocks, then go to WAIT_ECHO. The timeout counter is cleared on entry to WAIT_ECHO.
  - WAIT_ECHO:
    - A rising edge of echo_s goes to MEASURE; the sub-counter and cm-counter are cleared.
    - Only an edge counts: echo already high on entry is ignored until it falls and rises again.
    - If TIMEOUT_US*CLK_MHZ clocks elapse with no rise, go to DONE with timeout set.
  - MEASURE:
    - The sub-counter runs 0..58*CLK_MHZ-1; each wrap increments the cm-counter.
    - The cm-counter saturates at 2^DW-1 and does not wrap.
    - A falling edge of echo_s goes to DONE. The timeout counter is cleared on entry to MEASURE; if it reaches TIMEOUT_US*CLK_MHZ, go to DONE with timeout set.
  - DONE (1 cycle): publish results, then return to IDLE.
    - Normal: dist_cm=cm-counter, err=0, distancia=(cm-counter < UMBRAL_CM) (strict less-than).
    - Timeout: dist_cm=all ones, err=1, distancia=0.
    - valid=1 for this single cycle in both cases.
- Outputs hold their values between DONE cycles.
- Arithmetic is unsigned throughout; dist_cm = floor(echo_clocks / (58*CLK_MHZ)).
- Echo edges in IDLE or TRIG are ignored.

Test Plan:
- Bench uses CLK_MHZ=50, PERIOD_US=5000, TIMEOUT_US=2000.
- Reset: hold reset=0 for 20 ns, then release -> all outputs 0; trig rises 5000 µs after release and stays high exactly 500 clocks (10 µs).
- Near: echo high 580 µs, 100 µs after trig falls -> valid pulse; dist_cm=10, distancia=1, err=0.
- Threshold boundary:
  - Echo 1155 µs -> dist_cm=19, distancia=1.
  - Next cycle, echo 1165 µs -> dist_cm=20, distancia=0.
  - Echo 1740 µs -> dist_cm=30, distancia=0.
- Timeouts:
  - No echo -> valid exactly 2000 µs after entering WAIT_ECHO; dist_cm=511, err=1, distancia=0.
  - Echo stuck high 3000 µs -> same result.
  - Following good 580 µs echo -> err=0, dist_cm=10.
- Stale echo: echo already high when trig falls, then falls and later rises for 580 µs -> dist_cm=10 (the stale pulse is ignored).
- Mid-measurement reset: reset=0 during MEASURE -> trig=0 and outputs cleared immediately, no valid pulse; normal cycle resumes PERIOD_US after release.

Source files
------------

// File: rtl/sensor_distancia_hcsr04.sv
// HC-SR04 ultrasonic ranger driver: periodic trigger, echo width measurement,
// divider-free conversion to centimetres and a near-object presence flag.
module sensor_distancia_hcsr04 #(
    parameter int CLK_MHZ    = 50,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_US  = 60000,
    parameter int TIMEOUT_US = 25000,
    parameter int UMBRAL_CM  = 20,
    parameter int DW         = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          echo,
    output logic          trig,
    output logic [DW-1:0] dist_cm,
    output logic          distancia,
    output logic          valid,
    output logic          err
);
    localparam int PER_CYC  = PERIOD_US * CLK_MHZ;
    localparam int TRIG_CYC = TRIG_US * CLK_MHZ;
    localparam int TO_CYC   = TIMEOUT_US * CLK_MHZ;
    localparam int SUB_CYC  = 58 * CLK_MHZ;
    localparam int TMR_MAX  = (TO_CYC > TRIG_CYC) ? TO_CYC : TRIG_CYC;
    localparam int PW       = $clog2(PER_CYC + 1);
    localparam int TW       = $clog2(TMR_MAX + 1);
    localparam int SW       = $clog2(SUB_CYC);

    localparam logic [PW-1:0] PER_SAT   = PW'(PER_CYC);
    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(SUB_CYC - 1);
    localparam logic [DW-1:0] CM_MAX    = '1;
    localparam logic [DW-1:0] UMBRAL    = DW'(UMBRAL_CM);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    echo_sr_q;
    logic [PW-1:0] per_q, per_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [DW-1:0] cm_q, cm_d;
    logic [DW-1:0] dist_q, dist_d;
    logic          dcia_q, dcia_d;
    logic          err_q, err_d;
    logic          echo_rise, echo_fall;

    // [0] metastability stage, [1] synchronised echo, [2] previous sample
    assign echo_rise = echo_sr_q[1] & ~echo_sr_q[2];
    assign echo_fall = ~echo_sr_q[1] & echo_sr_q[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            echo_sr_q <= '0;
            per_q     <= '0;
            tmr_q     <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            dist_q    <= '0;
            dcia_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            echo_sr_q <= {echo_sr_q[1:0], echo};
            per_q     <= per_d;
            tmr_q     <= tmr_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            dist_q    <= dist_d;
            dcia_q    <= dcia_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        tmr_d   = tmr_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        dist_d  = dist_q;
        dcia_d  = dcia_q;
        err_d   = err_q;

        if (per_q != PER_SAT) per_d = per_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (per_q == PER_SAT) begin
                    state_d = TRIG;
                    per_d   = '0;
                    tmr_d   = '0;
                end
            end
            TRIG: begin
                if (tmr_q == TRIG_LAST) begin
                    state_d = WAIT_ECHO;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                    tmr_d   = '0;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (tmr_q == TO_LAST) begin
                    state_d = DONE;
                    dist_d  = '1;
                    dcia_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            MEASURE: begin
                // Counters advance on the falling-edge cycle too, so the
                // published value covers every echo clock.
                if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    if (cm_q != CM_MAX) cm_d = cm_q + 1'b1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
                tmr_d = tmr_q + 1'b1;
                if (echo_fall) begin
                    state_d = DONE;
                    dist_d  = cm_d;
                    dcia_d  = (cm_d < UMBRAL);
                    err_d   = 1'b0;
                end else if (tmr_q == TO_LAST) begin
                    state_d = DONE;
                    dist_d  = '1;
                    dcia_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Results are registered on entry to DONE so they are already stable
    // during the valid cycle.
    assign trig      = (state_q == TRIG);
    assign valid     = (state_q == DONE);
    assign dist_cm   = dist_q;
    assign distancia = dcia_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sensor_distancia_hcsr04.sv
// Directed and randomized bench for sensor_distancia_hcsr04 with a
// microsecond-level reference model of the published distance.
module tb_sensor_distancia_hcsr04;
    localparam int CLK_MHZ    = 50;
    localparam int TRIG_US    = 10;
    localparam int PERIOD_US  = 5000;
    localparam int TIMEOUT_US = 2000;
    localparam int UMBRAL_CM  = 20;
    localparam int DW         = 9;
    localparam int PER_CYC    = PERIOD_US * CLK_MHZ;
    localparam int TRIG_CYC   = TRIG_US * CLK_MHZ;
    localparam int TO_CYC     = TIMEOUT_US * CLK_MHZ;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          echo = 1'b0;
    logic          trig, distancia, valid, err;
    logic [DW-1:0] dist_cm;

    int            vectors = 0;
    int            miscompares = 0;

    int            valid_ticks;
    logic          got_valid;
    logic [DW-1:0] r_dist;
    logic          r_dcia, r_err, r_valid_next;

    always #10 clk = ~clk;

    sensor_distancia_hcsr04 #(
        .CLK_MHZ   (CLK_MHZ),
        .TRIG_US   (TRIG_US),
        .PERIOD_US (PERIOD_US),
        .TIMEOUT_US(TIMEOUT_US),
        .UMBRAL_CM (UMBRAL_CM),
        .DW        (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .echo     (echo),
        .trig     (trig),
        .dist_cm  (dist_cm),
        .distancia(distancia),
        .valid    (valid),
        .err      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sensor behaviour in microseconds: width/58 cm, or timeout if no echo
    // or an echo that outlasts the timeout window.
    function automatic void ref_model(input int width_us, output logic [DW-1:0] d,
                                      output logic p, output logic e);
        int cm;
        if (width_us == 0 || width_us >= TIMEOUT_US) begin
            d = '1;
            p = 1'b0;
            e = 1'b1;
        end else begin
            cm = width_us / 58;
            if (cm > (1 << DW) - 1) cm = (1 << DW) - 1;
            d = DW'(cm);
            p = (cm < UMBRAL_CM);
            e = 1'b0;
        end
    endfunction

    task automatic wait_trig_rise(output int n);
        n = 0;
        while (trig !== 1'b1 && n < PER_CYC + 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic trig_width(output int n);
        n = 0;
        while (trig === 1'b1 && n < TRIG_CYC + 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_echo(input int delay_us, input int width_us, input bit stale);
        int budget;
        budget = ((stale ? 200 : 0) + delay_us + width_us) * CLK_MHZ + TO_CYC + 200;
        fork
            begin
                if (stale) begin
                    repeat (200 * CLK_MHZ) tick();
                    echo = 1'b0;
                end
                repeat (delay_us * CLK_MHZ) tick();
                if (width_us > 0) begin
                    echo = 1'b1;
                    repeat (width_us * CLK_MHZ) tick();
                    echo = 1'b0;
                end
            end
            begin
                valid_ticks = 0;
                got_valid   = 1'b0;
                while (!got_valid && valid_ticks < budget) begin
                    tick();
                    valid_ticks++;
                    if (valid === 1'b1) got_valid = 1'b1;
                end
                r_dist = dist_cm;
                r_dcia = distancia;
                r_err  = err;
                tick();
                r_valid_next = valid;
            end
        join
    endtask

    task automatic finish_cycle(input string tag, input int delay_us, input int width_us,
                                input bit stale);
        int            n;
        logic [DW-1:0] e_dist;
        logic          e_dcia, e_err;
        if (stale) echo = 1'b1;
        trig_width(n);
        chk({tag, ".trig_w"}, n, TRIG_CYC);
        run_echo(delay_us, width_us, stale);
        ref_model(width_us, e_dist, e_dcia, e_err);
        chk({tag, ".valid"}, got_valid, 1);
        chk({tag, ".dist"}, r_dist, e_dist);
        chk({tag, ".distancia"}, r_dcia, e_dcia);
        chk({tag, ".err"}, r_err, e_err);
        chk({tag, ".pulse1"}, r_valid_next, 0);
        if (width_us == 0) chk({tag, ".to_lat"}, valid_ticks, TO_CYC);
    endtask

    task automatic do_cycle(input string tag, input int delay_us, input int width_us,
                            input bit stale);
        int n;
        wait_trig_rise(n);
        chk({tag, ".trig_seen"}, trig, 1);
        finish_cycle(tag, delay_us, width_us, stale);
    endtask

    initial begin
        int n, nv, w, d;

        #20 reset = 1'b1;
        #1;
        chk("rst.trig", trig, 0);
        chk("rst.dist", dist_cm, 0);
        chk("rst.distancia", distancia, 0);
        chk("rst.valid", valid, 0);
        chk("rst.err", err, 0);

        wait_trig_rise(n);
        chk("first_trig_time", (n >= PER_CYC && n <= PER_CYC + 3), 1);
        finish_cycle("near", 100, 580, 1'b0);

        do_cycle("cm19", 100, 1155, 1'b0);
        do_cycle("cm20", 100, 1165, 1'b0);
        do_cycle("cm30", 100, 1740, 1'b0);
        do_cycle("no_echo", 0, 0, 1'b0);
        do_cycle("stuck", 100, 3000, 1'b0);
        do_cycle("recover", 100, 580, 1'b0);

        for (int i = 0; i < 2; i++) begin
            w = $urandom_range(1900, 60);
            d = $urandom_range(400, 20);
            do_cycle($sformatf("rand%0d_w%0d", i, w), d, w, 1'b0);
        end

        do_cycle("stale", 100, 580, 1'b1);

        // Reset while the echo is being measured.
        wait_trig_rise(n);
        trig_width(n);
        repeat (100 * CLK_MHZ) tick();
        echo = 1'b1;
        repeat (300 * CLK_MHZ) tick();
        #5 reset = 1'b0;
        #1;
        chk("midrst.trig", trig, 0);
        chk("midrst.valid", valid, 0);
        chk("midrst.dist", dist_cm, 0);
        chk("midrst.distancia", distancia, 0);
        chk("midrst.err", err, 0);
        #100 echo = 1'b0;
        reset = 1'b1;

        n  = 0;
        nv = 0;
        while (trig !== 1'b1 && n < PER_CYC + 1000) begin
            tick();
            n++;
            if (valid === 1'b1) nv++;
        end
        chk("midrst.no_valid", nv, 0);
        chk("midrst.restart_time", (n >= PER_CYC && n <= PER_CYC + 3), 1);
        finish_cycle("after_rst", 100, 580, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
